// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: packs per-cycle write-back and data-memory events into records
// held in a circular FIFO drained via valid/ready. Define RISCV_TRACE_TS_EN to add a cycle timestamp.
module riscv_trace_buffer #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 16,
   parameter int OVERWRITE = 0,
   parameter int CNT_W     = 8,
   parameter int TS_W      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       trc_en,
   input  logic                       trc_clr,
   input  logic                       reg_write_sig,
   input  logic [4:0]                 reg_num,
   input  logic [DATA_W-1:0]          reg_data,
   input  logic                       wr,
   input  logic                       rd,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [DATA_W-1:0]          rd_data,
   output logic                       trc_valid,
   input  logic                       trc_ready,
   output logic                       trc_reg_v,
   output logic [4:0]                 trc_reg_num,
   output logic [DATA_W-1:0]          trc_reg_data,
   output logic                       trc_mem_wr,
   output logic                       trc_mem_rd,
   output logic [ADDR_W-1:0]          trc_addr,
   output logic [DATA_W-1:0]          trc_mem_data,
`ifdef RISCV_TRACE_TS_EN
   output logic [TS_W-1:0]            trc_ts,
`endif
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           lost_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || TS_W < 1) begin : g_bad_param
      $error("riscv_trace_buffer: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic              reg_v;
      logic [4:0]        reg_num;
      logic [DATA_W-1:0] reg_data;
      logic              mem_wr;
      logic              mem_rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] mem_data;
`ifdef RISCV_TRACE_TS_EN
      logic [TS_W-1:0]   ts;
`endif
   } rec_t;

   rec_t           mem_q [DEPTH];
   rec_t           mem_d [DEPTH];
   rec_t           rec_in;
   rec_t           head;
   logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]  lvl_q, lvl_d;
   logic [CNT_W-1:0] lost_q, lost_d;
   logic           push, pop, full;

`ifdef RISCV_TRACE_TS_EN
   logic [TS_W-1:0] ts_q, ts_d;

   always_comb ts_d = ts_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_d;
   end
`endif

   assign push = trc_en && (reg_write_sig || wr || rd);
   assign pop  = trc_valid && trc_ready;
   assign full = (lvl_q == FULL_LVL);

   // Unused halves of the record are zeroed so idle fields never leak stale bus values.
   always_comb begin
      rec_in = '0;
      if (reg_write_sig) begin
         rec_in.reg_v    = 1'b1;
         rec_in.reg_num  = reg_num;
         rec_in.reg_data = reg_data;
      end
      if (wr || rd) begin
         rec_in.mem_wr   = wr;
         rec_in.mem_rd   = rd;
         rec_in.addr     = addr;
         rec_in.mem_data = wr ? wr_data : rd_data;
      end
`ifdef RISCV_TRACE_TS_EN
      rec_in.ts = ts_q;
`endif
   end

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      lvl_d  = lvl_q;
      lost_d = lost_q;
      if (trc_clr) begin
         wptr_d = '0;
         rptr_d = '0;
         lvl_d  = '0;
         lost_d = '0;
      end else begin
         // When full in overwrite mode wptr == rptr, so the new record lands on the oldest one.
         if (push && (pop || !full || OVERWRITE != 0)) begin
            mem_d[wptr_q] = rec_in;
            wptr_d        = wptr_q + 1'b1;
         end
         if (pop || (push && full && OVERWRITE != 0))
            rptr_d = rptr_q + 1'b1;
         if (push && !pop && !full)
            lvl_d = lvl_q + 1'b1;
         else if (pop && !push)
            lvl_d = lvl_q - 1'b1;
         if (push && full && !pop && lost_q != '1)
            lost_d = lost_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         lvl_q  <= '0;
         lost_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         lvl_q  <= lvl_d;
         lost_q <= lost_d;
         mem_q  <= mem_d;
      end
   end

   assign head         = mem_q[rptr_q];
   assign trc_valid    = (lvl_q != '0);
   assign trc_reg_v    = head.reg_v;
   assign trc_reg_num  = head.reg_num;
   assign trc_reg_data = head.reg_data;
   assign trc_mem_wr   = head.mem_wr;
   assign trc_mem_rd   = head.mem_rd;
   assign trc_addr     = head.addr;
   assign trc_mem_data = head.mem_data;
`ifdef RISCV_TRACE_TS_EN
   assign trc_ts       = head.ts;
`endif
   assign level        = lvl_q;
   assign lost_cnt     = lost_q;

endmodule
